// File: rtl/alu_pkg.sv
// Shared op codes, M-extension funct3 values and the FSM state type for alu_md.
// The signedness helpers say which operands of an M op are treated as two's complement.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLL  = 4'b1110;
  localparam logic [3:0] OP_SRL  = 4'b1111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} alu_state_t;

  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath: works on operand magnitudes, one bit per cycle,
// and presents the sign-corrected result combinationally alongside the final step.
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_q, neg_d;
  logic               div0_q, div0_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic               q_bit;
  logic [2*WIDTH-1:0] mul_next, div_next, step_acc, prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    sa    = f3_signed_a(funct3) & a[WIDTH-1];
    sb    = f3_signed_b(funct3) & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;

    // acc = {partial product high, remaining multiplier}
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // acc = {partial remainder, dividend bits shifting into quotient}
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    q_bit     = ~div_trial[WIDTH];
    div_next  = {(q_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], q_bit};

    step_acc = f3_q[2] ? div_next : mul_next;
    prod     = neg_q ? -step_acc : step_acc;
    quo      = step_acc[WIDTH-1:0];
    rem      = step_acc[2*WIDTH-1:WIDTH];

    case (f3_q)
      F3_MUL:            result = prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:          result = prod[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:   result = div0_q ? '1 : (neg_q ? -quo : quo);
      default:           result = neg_q ? -rem : rem;
    endcase

    done   = (cnt_q == CW'(1));
    acc_d  = acc_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    f3_d   = f3_q;
    neg_d  = neg_q;
    div0_d = div0_q;
    if (start) begin
      acc_d  = {{WIDTH{1'b0}}, mag_a};
      opb_d  = mag_b;
      cnt_d  = CW'(WIDTH);
      f3_d   = funct3;
      // remainder takes the dividend's sign, everything else the product of signs
      neg_d  = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
      div0_d = (b == '0);
    end else if (cnt_q != '0) begin
      acc_d = step_acc;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
      div0_q <= div0_d;
    end
  end

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle RV32I base ops and iterative RV32M ops behind a
// valid/ready handshake on both sides; all outputs come straight from flops.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALU_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_res;
  logic             iter_start, iter_done;
  logic [WIDTH-1:0] iter_res;

  alu_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .a      (A),
    .b      (B),
    .funct3 (ALU_operation[2:0]),
    .done   (iter_done),
    .result (iter_res)
  );

  always_comb begin
    shamt = B[SHW-1:0];
    case (ALU_operation[3:0])
      OP_ADD:  base_res = A + B;
      OP_SUB:  base_res = A - B;
      OP_OR:   base_res = A | B;
      OP_AND:  base_res = A & B;
      OP_XOR:  base_res = A ^ B;
      OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, A < B};
      OP_SLL:  base_res = A << shamt;
      OP_SRL:  base_res = A >> shamt;
      OP_SRA:  base_res = $unsigned($signed(A) >>> shamt);
      default: base_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    zero_d     = zero_q;
    iter_start = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        if (ALU_operation[4]) begin
          iter_start = 1'b1;
          state_d    = CALC;
        end else begin
          res_d   = base_res;
          zero_d  = (base_res == '0);
          state_d = DONE;
        end
      end
      CALC: if (iter_done) begin
        res_d   = iter_res;
        zero_d  = (iter_res == '0);
        state_d = DONE;
      end
      default: if (out_ready) state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign res       = res_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: the driver queues reference results at accept time,
// the monitor compares result, zero flag and latency whenever out_valid is high.
module tb_alu_md;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [4:0]   op_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
  logic         zero;
  logic         busy;

  alu_md #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .A             (a_i),
    .B             (b_i),
    .ALU_operation (op_i),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .res           (res),
    .zero          (zero),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    logic [4:0]  op;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;  // 0 random, 1 always ready, 2 never ready

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference computed directly from the ISA definitions with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    if (!op[4]) begin
      case (op[3:0])
        4'b0010: return a + b;
        4'b0110: return a - b;
        4'b0001: return a | b;
        4'b0000: return a & b;
        4'b1100: return a ^ b;
        4'b0111: return {31'b0, sa < sb};
        4'b1001: return {31'b0, a < b};
        4'b1110: return a << b[4:0];
        4'b1111: return a >> b[4:0];
        4'b1101: return 32'(sa >>> b[4:0]);
        default: return 32'h0;
      endcase
    end
    case (op[2:0])
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // While the DUT is not ready, junk (sometimes with in_valid) is driven; it must be ignored.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      a_i = $urandom;
      b_i = $urandom;
      op_i = 5'($urandom);
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    a_i = a;
    b_i = b;
    op_i = op;
    if (push) q.push_back('{res: model(op, a, b), lat: (op[4] ? W + 1 : 1), op: op, acc: cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    op_i = 5'($urandom);
  endtask

  // Monitor: owns out_ready; checks the queue head every cycle out_valid is high.
  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        out_ready = 1'b0;
        continue;
      end
      case (rdy_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (busy) chk("in_ready_while_busy", in_ready, 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_output: out_valid=1 res=%0h, required no output", res);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk($sformatf("latency op=%0h", q[0].op), 64'(cyc - q[0].acc), 64'(q[0].lat));
          end
          chk($sformatf("res op=%0h", q[0].op), res, q[0].res);
          chk($sformatf("zero op=%0h", q[0].op), zero, q[0].res == 32'h0);
          chk("in_ready_while_valid", in_ready, 0);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[] = '{
    '{5'b00010, 32'h7FFF_FFFF, 32'h1},
    '{5'b01101, 32'h8000_0000, 32'h24},
    '{5'b01110, 32'h8000_0000, 32'h24},
    '{5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF},
    '{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF},
    '{5'b10101, 32'h7,         32'h0},
    '{5'b10111, 32'h7,         32'h0},
    '{5'b10100, 32'hFFFF_FFF9, 32'h2},
    '{5'b10110, 32'hFFFF_FFF9, 32'h2},
    '{5'b11100, 32'hFFFF_FFF9, 32'h2},
    '{5'b10010, 32'hFFFF_FFFE, 32'h3}
  };

  initial begin
    int          n;
    bit          saw;
    logic [31:0] snap;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_res", res, 0);
    chk("reset_zero", zero, 0);
    rst = 1'b0;

    rdy_mode = 1;
    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, 1'b1);

    // Abort a divide mid-calculation: nothing may come out afterwards.
    issue(5'b10101, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= out_valid;
    end
    chk("abort_no_output", saw, 0);

    // Hold a result with out_ready low; the monitor checks stability each cycle.
    rdy_mode = 2;
    issue(5'b10110, 32'hFFFF_FFF9, 32'h2, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_out_valid_seen", out_valid, 1);
    snap = res;
    repeat (5) @(negedge clk);
    chk("hold_res_stable", res, snap);
    chk("hold_out_valid", out_valid, 1);
    chk("hold_in_ready", in_ready, 0);
    rdy_mode = 0;

    for (int i = 0; i < 80; i++) issue(5'($urandom), pick(), pick(), 1'b1);

    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
